// File: rtl/seq_priority_encoder_8to3.sv
// seq_priority_encoder_8to3
//   Captures a request vector and streams out the index of every set bit,
//   lowest first, one index per valid/ready handshake.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   load       capture req_vec (ignored while busy)
//   req_vec    request vector, sampled on an accepted load
//   busy       captured bits remain to be emitted
//   out_valid  out_idx is valid
//   out_ready  consumer accepts out_idx this cycle
//   out_idx    index of the lowest pending set bit
//   out_last   current index is the final pending bit
//   zero_err   one-cycle pulse after a load accepted with req_vec == 0
//   pending    remaining un-emitted bits
// WIDTH must equal 2**IDX_W.
module seq_priority_encoder_8to3 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] req_vec,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             zero_err,
  output logic [WIDTH-1:0] pending
);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             zero_err_q, zero_err_d;
  logic [IDX_W-1:0] low_idx;
  logic             one_hot;
  logic             emitting;

  // Lowest set bit: scan from the top so the last hit (lowest) wins.
  always_comb begin
    low_idx = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        low_idx = IDX_W'(i);
      end
    end
  end

  // x & (x - 1) clears the lowest set bit; zero result means one bit was set.
  assign one_hot = (pending_q != '0) && ((pending_q & (pending_q - WIDTH'(1))) == '0);

  assign emitting  = (state_q == StEmit);
  assign busy      = emitting;
  assign out_valid = emitting;
  assign out_idx   = emitting ? low_idx : '0;
  assign out_last  = emitting & one_hot;
  assign zero_err  = zero_err_q;
  assign pending   = pending_q;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    zero_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          if (req_vec != '0) begin
            pending_d = req_vec;
            state_d   = StEmit;
          end else begin
            zero_err_d = 1'b1;
          end
        end
      end
      StEmit: begin
        // Loads are ignored here, including on the final transfer.
        if (out_ready) begin
          pending_d = pending_q & (pending_q - WIDTH'(1));
          if (one_hot) begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d   = StIdle;
        pending_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      zero_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      zero_err_q <= zero_err_d;
    end
  end

endmodule

// File: tb/tb_seq_priority_encoder_8to3.sv
// tb_seq_priority_encoder_8to3
//   Directed bench: expected (idx, last) pairs are queued when a vector is
//   loaded and popped as handshakes complete. Inputs change and outputs are
//   checked on the falling edge.
module tb_seq_priority_encoder_8to3;

  typedef struct packed {
    logic [2:0] idx;
    logic       last;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [7:0] req_vec;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_last;
  logic       zero_err;
  logic [7:0] pending;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  seq_priority_encoder_8to3 #(
    .WIDTH(8),
    .IDX_W(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .req_vec  (req_vec),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx  (out_idx),
    .out_last (out_last),
    .zero_err (zero_err),
    .pending  (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_idx"}, 32'(out_idx), 0);
    check({tag, "_last"}, 32'(out_last), 0);
    check({tag, "_pending"}, 32'(pending), 0);
  endtask

  // Expected stream for a vector: set bits lowest first, last on the final one.
  task automatic push_vec(input logic [7:0] v);
    int   remaining;
    exp_t e;
    remaining = $countones(v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        e.idx  = 3'(i);
        e.last = (remaining == 1);
        sb.push_back(e);
        remaining--;
      end
    end
  endtask

  // Drive load for one cycle with out_ready low; called on a falling edge.
  task automatic do_load(input logic [7:0] v, input bit accept, input string tag);
    out_ready = 1'b0;
    load      = 1'b1;
    req_vec   = v;
    if (accept && v != 8'h00) push_vec(v);
    @(negedge clk);
    load    = 1'b0;
    req_vec = 8'($urandom_range(255));
    check({tag, "_zero_err"}, 32'(zero_err), 32'(accept && v == 8'h00));
    if (accept) begin
      check({tag, "_busy"}, 32'(busy), 32'(v != 8'h00));
      check({tag, "_pending"}, 32'(pending), 32'(v));
    end
    if (accept && v == 8'h00) begin
      @(negedge clk);
      check({tag, "_zero_err_pulse"}, 32'(zero_err), 0);
      check({tag, "_zero_busy"}, 32'(busy), 0);
      check({tag, "_zero_valid"}, 32'(out_valid), 0);
    end
  endtask

  // Drain the scoreboard; toggle=1 gives ready pattern 1,0,0,1,0,0,...
  task automatic drain(input bit toggle, input string tag);
    int   cyc  = 0;
    bit   done = 1'b0;
    exp_t e;
    while (!done && cyc < 64) begin
      if (sb.size() == 0 && !busy) begin
        done = 1'b1;
      end else begin
        out_ready = toggle ? (cyc % 3 == 0) : 1'b1;
        check({tag, "_valid"}, 32'(out_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
          e = sb[0];
          check({tag, "_idx"}, 32'(out_idx), 32'(e.idx));
          check({tag, "_last"}, 32'(out_last), 32'(e.last));
          if (out_ready && out_valid) void'(sb.pop_front());
        end
        @(negedge clk);
        cyc++;
      end
    end
    out_ready = 1'b0;
    check({tag, "_done"}, 32'(done), 1);
    check_idle_outputs({tag, "_end"});
    sb.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    load      = 1'b0;
    req_vec   = 8'h00;
    out_ready = 1'b0;
    #2;
    check_idle_outputs("reset");
    check("reset_zero_err", 32'(zero_err), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Two far-apart bits.
    do_load(8'b1000_0001, 1'b1, "t1_load");
    drain(1'b0, "t1");

    // One-hot sweep.
    for (int i = 0; i < 8; i++) begin
      do_load(8'b1 << i, 1'b1, $sformatf("t2_load%0d", i));
      check($sformatf("t2_roundtrip%0d", i), 32'(8'b1 << out_idx), 32'(8'b1 << i));
      drain(1'b0, $sformatf("t2_%0d", i));
    end

    // Zero vector.
    do_load(8'h00, 1'b1, "t3");

    // All bits set with stalls.
    do_load(8'hFF, 1'b1, "t4_load");
    drain(1'b1, "t4");

    // Load while busy is ignored.
    do_load(8'h0C, 1'b1, "t5_load");
    do_load(8'hF0, 1'b0, "t5_busy_load");
    check("t5_busy", 32'(busy), 1);
    check("t5_pending", 32'(pending), 32'h0C);
    drain(1'b0, "t5");

    // Load coinciding with the final transfer is ignored.
    do_load(8'h80, 1'b1, "t7_load");
    check("t7_idx", 32'(out_idx), 7);
    check("t7_last", 32'(out_last), 1);
    out_ready = 1'b1;
    load      = 1'b1;
    req_vec   = 8'h01;
    @(negedge clk);
    load      = 1'b0;
    out_ready = 1'b0;
    check_idle_outputs("t7_after");
    check("t7_zero_err", 32'(zero_err), 0);
    sb.delete();
    @(negedge clk);
    check("t7_still_idle", 32'(busy), 0);

    // Reset in the middle of emission.
    do_load(8'hAA, 1'b1, "t6_load");
    out_ready = 1'b1;
    check("t6_first_idx", 32'(out_idx), 32'(sb[0].idx));
    void'(sb.pop_front());
    @(negedge clk);
    out_ready = 1'b0;
    check("t6_second_idx", 32'(out_idx), 3);
    check("t6_pending", 32'(pending), 32'hA8);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t6_rst");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_post_rst_busy", 32'(busy), 0);
    do_load(8'h10, 1'b1, "t6_reload");
    drain(1'b0, "t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
